ingress_queue: RTL and testbench

- Per-port input buffer on the write side of the 4-port switch fabric; four instances, one per ingress port.
- Captures bytes from the port receive stream, which has no backpressure, into a show-ahead FIFO.
- Presents the head byte to the scheduler as its per-port `data` input; the destination field is bits [1:0].
- Pops the head when the scheduler asserts this port's `rdreq`.
- Reports occupancy, almost-full and overflow drops to the fabric.

---
 rtl/switch_pkg.sv | 15 +
 rtl/sync_fifo_mem.sv | 41 ++++
 rtl/ingress_queue.sv | 102 ++++++++++
 tb/tb_ingress_queue.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared switch-fabric types and helpers used by the ingress queues and scheduler.
package switch_pkg;

    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned PORT_W    = 2;
    localparam int unsigned DATA_W    = 8;

    typedef logic [PORT_W-1:0] port_t;

    // Destination port carried in the low bits of every byte.
    function automatic port_t dest_of(input logic [DATA_W-1:0] b);
        return b[PORT_W-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage with one write port and a registered show-ahead head.
module sync_fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    input  logic              rvalid_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] head_q;

    // Storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Head register loads the entry at the next read address; a byte written
    // to that same address this cycle is forwarded so it shows one edge later.
    always_ff @(posedge clk) begin
        if (!rst_n || !rvalid_i) begin
            head_q <= '0;
        end else if (we_i && (waddr_i == raddr_i)) begin
            head_q <= wdata_i;
        end else begin
            head_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = head_q;

endmodule

// File: rtl/ingress_queue.sv
// Per-port ingress buffer: show-ahead FIFO with occupancy, almost-full and drop counter.
module ingress_queue
    import switch_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AFULL_TH = 12,
    parameter int unsigned PORT_ID  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx_valid,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic                       rdreq,
    output logic [DATA_W-1:0]          data_out,
    output logic                       head_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic [15:0]                drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

    if (PORT_ID >= NUM_PORTS) begin : g_bad_port_id
        $error("ingress_queue: PORT_ID out of range");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("ingress_queue: DEPTH must be a power of two >= 2");
    end

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          afull_q, afull_d;
    logic          hvalid_q;
    logic [15:0]   drop_q, drop_d;
    logic          empty, full, push, pop;

    // Accept/pop decisions and next-state values for pointers, count and flags.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = rdreq && !empty;
        push     = rx_valid && (!full || pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        afull_d = (count_d >= AFULL_C);
        drop_d  = drop_q;
        if (rx_valid && !push && (drop_q != '1)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            afull_q  <= 1'b0;
            hvalid_q <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            afull_q  <= afull_d;
            hvalid_q <= (count_d != '0);
            drop_q   <= drop_d;
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (push && rst_n),
        .waddr_i  (wr_ptr_q[AW-1:0]),
        .wdata_i  (rx_data),
        .raddr_i  (rd_ptr_d[AW-1:0]),
        .rvalid_i (count_d != '0),
        .rdata_o  (data_out)
    );

    assign head_valid  = hvalid_q;
    assign count       = count_q;
    assign almost_full = afull_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_ingress_queue.sv
// Directed self-checking bench for ingress_queue (DEPTH 16, AFULL_TH 12).
module tb_ingress_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rdreq;
    logic [7:0]  data_out;
    logic        head_valid;
    logic [4:0]  count;
    logic        almost_full;
    logic [15:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    ingress_queue #(
        .DATA_W   (8),
        .DEPTH    (16),
        .AFULL_TH (12),
        .PORT_ID  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rdreq       (rdreq),
        .data_out    (data_out),
        .head_valid  (head_valid),
        .count       (count),
        .almost_full (almost_full),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_q[$];
        int next_push;
        int next_pop;
        int cyc;
        logic [7:0] v;

        rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; rdreq = 1'b0;

        // Reset then idle
        tick(); tick();
        chk("rst_hv", head_valid, 0);
        chk("rst_cnt", count, 0);
        chk("rst_data", data_out, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_af", almost_full, 0);
        rst_n = 1'b1;
        rdreq = 1'b1;
        tick(); tick();
        rdreq = 1'b0;
        chk("empty_pop_hv", head_valid, 0);
        chk("empty_pop_cnt", count, 0);
        chk("empty_pop_data", data_out, 0);
        chk("empty_pop_drop", drop_cnt, 0);

        // Single byte
        rx_valid = 1'b1; rx_data = 8'hA6;
        tick();
        rx_valid = 1'b0;
        chk("single_hv", head_valid, 1);
        chk("single_data", data_out, 8'hA6);
        chk("single_dest", switch_pkg::dest_of(data_out), 2);
        chk("single_cnt", count, 1);
        tick();
        chk("single_hold_data", data_out, 8'hA6);
        rdreq = 1'b1;
        tick();
        rdreq = 1'b0;
        chk("single_pop_hv", head_valid, 0);
        chk("single_pop_cnt", count, 0);
        chk("single_pop_data", data_out, 0);

        // Ordering with wrap: push 3 of every 4 cycles, pop every other cycle
        next_push = 0; next_pop = 0; cyc = 0;
        while (next_pop < 40 && cyc < 200) begin
            rx_valid = (next_push < 40) && (cyc % 4 != 3);
            rx_data  = 8'(next_push);
            rdreq    = (cyc % 2 == 1) || (next_push >= 40);
            if (rdreq && exp_q.size() > 0) begin
                chk("order_data", data_out, exp_q[0]);
                void'(exp_q.pop_front());
                next_pop++;
            end
            if (rx_valid) begin
                exp_q.push_back(next_push);
                next_push++;
            end
            tick();
            chk("order_cnt", count, exp_q.size());
            chk("order_hv", head_valid, (exp_q.size() != 0));
            chk("order_af", almost_full, (exp_q.size() >= 12));
            cyc++;
        end
        rx_valid = 1'b0; rdreq = 1'b0;
        chk("order_all_popped", next_pop, 40);
        chk("order_drop", drop_cnt, 0);
        chk("order_empty_hv", head_valid, 0);

        // Overflow: 20 bytes, no pops
        for (int i = 0; i < 20; i++) begin
            rx_valid = 1'b1; rx_data = 8'(i);
            tick();
            chk("ovf_cnt", count, (i + 1 > 16) ? 16 : i + 1);
            chk("ovf_af", almost_full, (i + 1 >= 12));
        end
        rx_valid = 1'b0;
        chk("ovf_drop", drop_cnt, 4);
        chk("ovf_head", data_out, 0);

        // Full with simultaneous push and pop
        rx_valid = 1'b1; rx_data = 8'h55; rdreq = 1'b1;
        tick();
        rx_valid = 1'b0; rdreq = 1'b0;
        chk("fullpp_cnt", count, 16);
        chk("fullpp_drop", drop_cnt, 4);
        chk("fullpp_head", data_out, 1);
        for (int i = 1; i <= 16; i++) begin
            v = (i == 16) ? 8'h55 : 8'(i);
            chk("drain_data", data_out, v);
            rdreq = 1'b1;
            tick();
            rdreq = 1'b0;
        end
        chk("drain_cnt", count, 0);
        chk("drain_hv", head_valid, 0);
        chk("drain_data0", data_out, 0);
        chk("drain_af", almost_full, 0);

        // Reset mid-operation
        for (int i = 0; i < 9; i++) begin
            rx_valid = 1'b1; rx_data = 8'(8'hC0 + i);
            tick();
        end
        chk("mid_cnt9", count, 9);
        rst_n = 1'b0; rx_valid = 1'b1; rx_data = 8'h77; rdreq = 1'b1;
        tick();
        rdreq = 1'b0;
        chk("midrst_cnt", count, 0);
        chk("midrst_hv", head_valid, 0);
        chk("midrst_drop", drop_cnt, 0);
        chk("midrst_data", data_out, 0);
        rst_n = 1'b1; rx_valid = 1'b1; rx_data = 8'h3C;
        tick();
        rx_valid = 1'b0;
        chk("post_rst_hv", head_valid, 1);
        chk("post_rst_data", data_out, 8'h3C);
        chk("post_rst_cnt", count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
